// File: rtl/alu_pkg.sv
// Shared phase encoding, key classes and register-file slot numbers
// for the calculator keypad entry sequencer.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_A   = 2'd0,
    OP_SEL = 2'd1,
    OP_B   = 2'd2,
    RESULT = 2'd3
  } phase_t;

  localparam logic [3:0] KEY_CLR   = 4'hE;
  localparam logic [3:0] OPC_MIN   = 4'hA;
  localparam logic [3:0] OPC_MAX   = 4'hD;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  localparam logic [1:0] ADDR_A  = 2'd0;
  localparam logic [1:0] ADDR_OP = 2'd1;
  localparam logic [1:0] ADDR_B  = 2'd2;

  function automatic logic is_digit(input logic [3:0] k);
    return (k <= DIGIT_MAX);
  endfunction

  function automatic logic is_opcode(input logic [3:0] k);
    return (k >= OPC_MIN) && (k <= OPC_MAX);
  endfunction

endpackage

// File: rtl/alu_entry_ctrl_key_edge.sv
// Keypad capture: latches the code while a key is held and flags the
// release edge, which is the single acceptance point of each press.
module key_edge (
  input  logic       clk,
  input  logic       reset,
  input  logic       released,
  input  logic [3:0] key,
  output logic       accept,
  output logic [3:0] code
);

  logic [3:0] key_q;
  logic       rel_q;

  // rel_q resets high so a key already up at reset never looks like a release
  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= 4'd0;
      rel_q <= 1'b1;
    end else begin
      rel_q <= released;
      if (!released) begin
        key_q <= key;
      end
    end
  end

  assign accept = ~rel_q & released;
  assign code   = key_q;

endmodule

// File: rtl/alu_entry_ctrl.sv
// Entry sequencer for the 4-bit calculator: A, operation, B, result,
// with key validation, a clear key and an inactivity auto-clear.
module alu_entry_ctrl
  import alu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int TMR_W          = 26
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       released,
  input  logic [3:0] key,
  output logic       wr_en,
  output logic [1:0] wr_addr,
  output logic [3:0] wr_data,
  output logic       clr,
  output logic       calc_en,
  output logic [1:0] phase,
  output logic       ready,
  output logic       err
);

  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  logic             accept;
  logic [3:0]       code;
  phase_t           phase_q, phase_d;
  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             wr_en_q, wr_en_d;
  logic             clr_q, clr_d;
  logic             err_q, err_d;
  logic [1:0]       wr_addr_q, wr_addr_d;
  logic [3:0]       wr_data_q, wr_data_d;
  logic             timing;
  logic             timeout;

  key_edge u_key_edge (
    .clk      (clk),
    .reset    (reset),
    .released (released),
    .key      (key),
    .accept   (accept),
    .code     (code)
  );

  // Next state, strobes and timeout; an accepted key always beats the timeout
  always_comb begin
    phase_d   = phase_q;
    wr_en_d   = 1'b0;
    clr_d     = 1'b0;
    err_d     = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    timing    = (phase_q == OP_SEL) || (phase_q == OP_B);
    timeout   = timing && (cnt_q == TMR_LAST);

    if (accept || !timing || timeout) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + TMR_W'(1);
    end

    if (accept) begin
      if (code == KEY_CLR) begin
        clr_d   = 1'b1;
        phase_d = OP_A;
      end else begin
        case (phase_q)
          OP_A: begin
            if (is_digit(code)) begin
              wr_en_d = 1'b1; wr_addr_d = ADDR_A; wr_data_d = code; phase_d = OP_SEL;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_SEL: begin
            if (is_opcode(code)) begin
              wr_en_d = 1'b1; wr_addr_d = ADDR_OP; wr_data_d = code; phase_d = OP_B;
            end else begin
              err_d = 1'b1;
            end
          end
          OP_B: begin
            if (is_digit(code)) begin
              wr_en_d = 1'b1; wr_addr_d = ADDR_B; wr_data_d = code; phase_d = RESULT;
            end else begin
              err_d = 1'b1;
            end
          end
          RESULT: begin
            // new digit starts a fresh calculation; the register file clears before writing
            if (is_digit(code)) begin
              clr_d = 1'b1; wr_en_d = 1'b1; wr_addr_d = ADDR_A; wr_data_d = code; phase_d = OP_SEL;
            end else begin
              err_d = 1'b1;
            end
          end
          default: begin
            err_d   = 1'b1;
            phase_d = OP_A;
          end
        endcase
      end
    end else if (timeout) begin
      clr_d   = 1'b1;
      phase_d = OP_A;
    end else begin
      phase_d = phase_q;
    end
  end

  // State, counter and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q   <= OP_A;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      clr_q     <= 1'b0;
      err_q     <= 1'b0;
      wr_addr_q <= 2'd0;
      wr_data_q <= 4'd0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      clr_q     <= clr_d;
      err_q     <= err_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign clr     = clr_q;
  assign err     = err_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign phase   = phase_q;
  assign calc_en = (phase_q == RESULT);
  assign ready   = released & ((phase_q == OP_A) | (phase_q == RESULT));

endmodule
